program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/common.sv | 20 ++
 rtl/program_loader_if.sv | 42 ++++
 rtl/program_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/common.sv
// -----------------------------------------------------------------------------
// common
// Shared types and constants for the program loader.
//   loader_state_t   : loader FSM states
//   LOADER_LEN_BYTES : number of little-endian length bytes at the head of a frame
// -----------------------------------------------------------------------------
package common;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    localparam int LOADER_LEN_BYTES = 4;

endpackage

// File: rtl/program_loader_if.sv
// -----------------------------------------------------------------------------
// program_loader_if
// Byte-stream input and instruction-memory write port of the program loader.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is no
// ready/backpressure, so the loader consumes every byte it is given in the
// states that accept bytes. write_enable is a one-cycle strobe qualifying
// write_address/write_data; those two hold their last value otherwise.
//
//   rx_valid      : byte strobe (stream source -> loader)
//   rx_data       : received byte
//   write_address : byte address into instruction memory (loader -> memory)
//   write_data    : byte to write
//   write_enable  : one-cycle write strobe
//
// Modports: master = loader side, slave = stream source / memory side.
// -----------------------------------------------------------------------------
interface program_loader_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] write_address;
    logic [7:0]  write_data;
    logic        write_enable;

    modport master (
        input  rx_valid,
        input  rx_data,
        output write_address,
        output write_data,
        output write_enable
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  write_address,
        input  write_data,
        input  write_enable
    );

endinterface

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Receives a frame {4 length bytes (LE), LEN payload bytes, XOR checksum byte}
// and writes the payload into instruction memory at BASE_ADDR + index.
//
// Ports:
//   clk         : clock, all state changes on rising edge
//   reset_n     : asynchronous active-low reset
//   start       : arms a new load (ignored while busy)
//   bus         : program_loader_if.master (rx stream in, memory write port out)
//   busy        : registered, high in LEN/DATA/CHK
//   done        : registered, high in DONE (core reset = reset_n & done)
//   error       : registered, high in ERR
//   o_dbg_state : current FSM state, for observation only
// -----------------------------------------------------------------------------
module program_loader
    import common::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_LEN   = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    program_loader_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output loader_state_t    o_dbg_state
);

    loader_state_t r_state;
    loader_state_t w_state_next;

    logic [31:0] r_len;
    logic [31:0] r_idx;
    logic [7:0]  r_csum;
    logic [1:0]  r_byte_cnt;

    logic [31:0] r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_wr_en;
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    logic        w_clear;
    logic        w_len_byte;
    logic        w_data_byte;
    logic [31:0] w_len_next;

    // Length register is cleared on entry to LEN, so OR-ing the byte into
    // its lane is the same as writing bits [8k+7:8k].
    assign w_len_next = r_len | ({24'h0, bus.rx_data} << {r_byte_cnt, 3'b000});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_len_byte   = 1'b0;
        w_data_byte  = 1'b0;
        case (r_state)
            // rx_valid is ignored here; a coincident byte is discarded.
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_state_next = ST_LEN;
                    w_clear      = 1'b1;
                end
            end
            ST_LEN: begin
                if (bus.rx_valid) begin
                    w_len_byte = 1'b1;
                    if (r_byte_cnt == 2'(LOADER_LEN_BYTES - 1)) begin
                        if (w_len_next > 32'(MAX_LEN)) begin
                            w_state_next = ST_ERR;
                        end else if (w_len_next == 32'd0) begin
                            w_state_next = ST_CHK;
                        end else begin
                            w_state_next = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (bus.rx_valid) begin
                    w_data_byte = 1'b1;
                    if (r_idx == r_len - 32'd1) begin
                        w_state_next = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (bus.rx_valid) begin
                    w_state_next = (bus.rx_data == r_csum) ? ST_DONE : ST_ERR;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len      <= '0;
            r_idx      <= '0;
            r_csum     <= '0;
            r_byte_cnt <= '0;
            r_wr_addr  <= BASE_ADDR;
            r_wr_data  <= '0;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            // Status flags are decoded from the next state so they line up
            // exactly with the state register.
            r_busy  <= (w_state_next == ST_LEN) || (w_state_next == ST_DATA) ||
                       (w_state_next == ST_CHK);
            r_done  <= (w_state_next == ST_DONE);
            r_error <= (w_state_next == ST_ERR);
            r_wr_en <= w_data_byte;

            if (w_clear) begin
                r_len      <= '0;
                r_idx      <= '0;
                r_csum     <= '0;
                r_byte_cnt <= '0;
            end
            if (w_len_byte) begin
                r_len      <= w_len_next;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (w_data_byte) begin
                r_wr_addr <= BASE_ADDR + r_idx;   // wraps modulo 2^32
                r_wr_data <= bus.rx_data;
                r_idx     <= r_idx + 32'd1;
                r_csum    <= r_csum ^ bus.rx_data;
            end
        end
    end

    assign bus.write_address = r_wr_addr;
    assign bus.write_data    = r_wr_data;
    assign bus.write_enable  = r_wr_en;
    assign busy              = r_busy;
    assign done              = r_done;
    assign error             = r_error;
    assign o_dbg_state       = r_state;

endmodule
